// File: rtl/cla_pkg.sv
// Shared types and constants for the multi-precision CLA add/subtract sequencer.
package cla_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width for indexing n words; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cla_wide_add_seq_if.sv
// Request/result bundle between a wide-arithmetic requester and the sequencer.
interface cla_wide_add_seq_if
    import cla_pkg::*;
#(
    parameter int NWORDS = 4
);
    localparam int W = WORD_W * NWORDS;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/cla_wide_add_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module CLA32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gc    = '0;
        c     = '0;
        gg    = '0;
        gp    = '0;
        gc[0] = cin;
        for (int i = 0; i < 8; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
            // In-group carries come straight from the group carry-in, not rippled.
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
            gc[i+1]  = gg[i] | (gp[i] & gc[i]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[8];

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-precision add/subtract: one shared CLA32 slice walks the operands LSW first,
// carry registered between words; one result per NWORDS+2 cycles.
module cla_wide_add_seq
    import cla_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input logic               clk,
    input logic               rst,
    cla_wide_add_seq_if.slave bus
);

    localparam int              W      = WORD_W * NWORDS;
    localparam int              KW     = clog2(NWORDS);
    localparam logic [KW-1:0]   K_LAST = KW'(NWORDS - 1);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [WORD_W-1:0] sl_a, sl_b, sl_sum;
    logic              sl_cout;

    assign sl_a = a_q[k_q*WORD_W +: WORD_W];
    assign sl_b = b_q[k_q*WORD_W +: WORD_W];

    CLA32bit u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    // cin is already the inverted borrow for subtract, so it feeds the slice as-is.
                    carry_d = bus.cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*WORD_W +: WORD_W] = sl_sum;
                carry_d = sl_cout;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cout_d  = sl_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sl_sum[WORD_W-1] != a_q[W-1]);
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for cla_wide_add_seq at NWORDS=4 (W=128).
module tb_cla_wide_add_seq;
    import cla_pkg::*;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    cla_wide_add_seq_if #(.NWORDS(NW)) bus ();

    cla_wide_add_seq #(.NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic s, input logic c,
                          input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        bus.sub   = s;
        bus.cin   = c;
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = {4{$urandom()}};
        bus.b     = {4{$urandom()}};
        bus.sub   = ~s;
        bus.cin   = ~c;
        chk({nm, ".busy"}, W'(bus.busy), W'(1));
        n = 1;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".lat"}, W'(n), W'(NW + 1));
        chk({nm, ".sum"}, bus.sum, es);
        chk({nm, ".cout"}, W'(bus.cout), W'(ec));
        chk({nm, ".ovf"}, W'(bus.ovf), W'(eo));
        @(negedge clk);
        chk({nm, ".done_1cyc"}, W'(bus.done), W'(0));
        chk({nm, ".idle"}, W'(bus.busy), W'(0));
        chk({nm, ".hold"}, bus.sum, es);
    endtask

    initial begin
        int cnt, last;
        logic [W-1:0] held;
        logic prev_done;
        tests = 0;
        fails = 0;

        vecs[0] = '{1'b0, 1'b0, {W{1'b1}}, W'(1), W'(0), 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, W'(5), W'(3), W'(2), 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, W'(3), W'(5), {{(W-2){1'b1}}, 2'b10}, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, {1'b0, {(W-1){1'b1}}}, W'(1), {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, W'(0), W'(0), W'(1), 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, W'(0), 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, W'(32'hFFFF_FFFF), W'(1), W'(64'h1_0000_0000), 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, W'(0), W'(1), {W{1'b1}}, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, {1'b1, {(W-1){1'b0}}}, W'(1), {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                    128'h11111111_11111111_11111111_11111111,
                    128'h12345678_9ABCDF01_0FEDCBA9_87654321, 1'b0, 1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.cin = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", W'(bus.busy), W'(0));
        chk("rst.done", W'(bus.done), W'(0));
        chk("rst.sum", bus.sum, W'(0));
        chk("rst.cout", W'(bus.cout), W'(0));
        chk("rst.ovf", W'(bus.ovf), W'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);

        // Second start at E2 must be dropped.
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b0; bus.a = W'(1); bus.b = W'(1); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = W'(9); bus.b = W'(9); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        held = '0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                cnt++;
                held = bus.sum;
            end
            @(negedge clk);
        end
        chk("busy_ign.ndone", W'(cnt), W'(1));
        chk("busy_ign.sum", held, W'(2));
        run_op("after_ign", 1'b0, 1'b0, W'(9), W'(9), W'(18), 1'b0, 1'b0);

        // Reset mid-RUN after an op that left cout=1.
        run_op("pre_rst", 1'b0, 1'b0, {W{1'b1}}, W'(2), W'(1), 1'b1, 1'b0);
        @(negedge clk);
        bus.a = W'(5); bus.b = W'(5); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", W'(bus.busy), W'(0));
        chk("midrst.done", W'(bus.done), W'(0));
        chk("midrst.sum", bus.sum, W'(0));
        chk("midrst.cout", W'(bus.cout), W'(0));
        chk("midrst.ovf", W'(bus.ovf), W'(0));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("midrst.nodone", W'(cnt), W'(0));
        run_op("post_rst", 1'b0, 1'b0, W'(5), W'(5), W'(10), 1'b0, 1'b0);

        // start held high: one accept per NW+2 cycles, operand a advanced at each done.
        @(negedge clk);
        bus.sub = 1'b0; bus.cin = 1'b0; bus.a = W'(1); bus.b = W'(100); bus.start = 1'b1;
        cnt = 0;
        last = 0;
        prev_done = 1'b0;
        held = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (prev_done) chk("b2b.hold", bus.sum, held);
            if (bus.done) begin
                cnt++;
                chk($sformatf("b2b.sum%0d", cnt), bus.sum, W'(cnt + 100));
                if (cnt == 1) chk("b2b.first", W'(i), W'(NW + 1));
                else          chk($sformatf("b2b.gap%0d", cnt), W'(i - last), W'(NW + 2));
                last = i;
                held = bus.sum;
                bus.a = W'(cnt + 1);
            end
            prev_done = bus.done;
        end
        bus.start = 1'b0;
        chk("b2b.count", W'(cnt), W'(6));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
